// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters (CPU, DMA), the arbiter and the data memory.
// The arbiter connects through the slave modport; the masters and the memory
// model connect through the master modport.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Master 0 (CPU)
    logic                  m0_req;
    logic [2:0]            m0_ctrl;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;
    logic                  cpu_stall;
    // Master 1 (DMA / loader)
    logic                  m1_req;
    logic                  m1_lock;
    logic [2:0]            m1_ctrl;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;
    // Memory side
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_ctrl;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_ctrl, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_ctrl, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_rdata, m0_ack, cpu_stall,
        output m1_rdata, m1_ack,
        output mem_addr, mem_wdata, mem_ctrl
    );

    modport master (
        output m0_req, m0_ctrl, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_ctrl, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_rdata, m0_ack, cpu_stall,
        input  m1_rdata, m1_ack,
        input  mem_addr, mem_wdata, mem_ctrl
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the single data memory port: CPU (master 0) and DMA
// (master 1). Registered round-robin grant, bounded burst lock for master 1,
// and a stall output that freezes the CPU while it does not own the bus.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  InputClk,
    input  logic                  rst,
`ifdef ARB_STATS_EN
    output logic [DATA_WIDTH-1:0] grant0_cnt,
    output logic [DATA_WIDTH-1:0] grant1_cnt,
    output logic [DATA_WIDTH-1:0] contend_cnt,
`endif
    mem_bus_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    // Last burst_cnt value at which master 1 may still retain the bus.
    localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

    state_e     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;

    logic                  lock_hold;
    logic                  m0_ack, m1_ack;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_ctrl;
    logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;

    // With MAX_BURST == 1 BurstLast is 0 and the comparison is never true.
    assign lock_hold = (state_q == StOwn1) && bus.m1_req && bus.m1_lock &&
                       (burst_cnt_q < BurstLast);

    // Arbitration state registers; reset aborts any ownership immediately.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Next owner: lock retention first, then round-robin on contention.
    always_comb begin
        state_d      = StIdle;
        last_owner_d = last_owner_q;
        burst_cnt_d  = 4'd0;
        if (lock_hold) begin
            state_d     = StOwn1;
            burst_cnt_d = burst_cnt_q + 4'd1;
        end else if (bus.m0_req && bus.m1_req) begin
            state_d = last_owner_q ? StOwn0 : StOwn1;
        end else if (bus.m0_req) begin
            state_d = StOwn0;
        end else if (bus.m1_req) begin
            state_d = StOwn1;
        end
        unique case (state_d)
            StOwn0:  last_owner_d = 1'b0;
            StOwn1:  last_owner_d = 1'b1;
            default: last_owner_d = last_owner_q;
        endcase
    end

    // Datapath mux; the owner is served only while it keeps req high. While
    // rst is low the state is forced to StIdle, so mem_ctrl is already 0.
    always_comb begin
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_ctrl  = 3'b000;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (state_q == StOwn0 && bus.m0_req) begin
            m0_ack    = 1'b1;
            mem_addr  = bus.m0_addr;
            mem_wdata = bus.m0_wdata;
            mem_ctrl  = bus.m0_ctrl;
            m0_rdata  = bus.mem_rdata;
        end else if (state_q == StOwn1 && bus.m1_req) begin
            m1_ack    = 1'b1;
            mem_addr  = bus.m1_addr;
            mem_wdata = bus.m1_wdata;
            mem_ctrl  = bus.m1_ctrl;
            m1_rdata  = bus.mem_rdata;
        end
    end

    assign bus.m0_ack    = m0_ack;
    assign bus.m1_ack    = m1_ack;
    assign bus.m0_rdata  = m0_rdata;
    assign bus.m1_rdata  = m1_rdata;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_ctrl  = mem_ctrl;
    assign bus.cpu_stall = bus.m0_req & ~m0_ack;

`ifdef ARB_STATS_EN
    logic [DATA_WIDTH-1:0] grant0_cnt_q, grant1_cnt_q, contend_cnt_q;

    // Saturating activity counters.
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            grant0_cnt_q  <= '0;
            grant1_cnt_q  <= '0;
            contend_cnt_q <= '0;
        end else begin
            if (m0_ack && (grant0_cnt_q != '1)) begin
                grant0_cnt_q <= grant0_cnt_q + DATA_WIDTH'(1);
            end
            if (m1_ack && (grant1_cnt_q != '1)) begin
                grant1_cnt_q <= grant1_cnt_q + DATA_WIDTH'(1);
            end
            if (bus.m0_req && bus.m1_req && (contend_cnt_q != '1)) begin
                contend_cnt_q <= contend_cnt_q + DATA_WIDTH'(1);
            end
        end
    end

    assign grant0_cnt  = grant0_cnt_q;
    assign grant1_cnt  = grant1_cnt_q;
    assign contend_cnt = contend_cnt_q;
`endif

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data memory port between the CPU (master 0) and a DMA/loader engine (master 1).
- Sits between the CPU bus outputs (address, data out, 3-bit control) and the DataMemory.
- Uses registered round-robin grant, optional bounded burst lock for master 1, and a stall output that freezes the CPU while it lacks the bus.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width.
- MAX_BURST, 4, maximum consecutive owned cycles for master 1 under lock (1..15).

Ports:
- InputClk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0_req  in  1  CPU request, equal to CPU ControlBus[1] | ControlBus[2].
- m0_ctrl  in  3  CPU control: bit1 read, bit2 write, bit0 ignored and passed through.
- m0_addr  in  ADDR_WIDTH  CPU address.
- m0_wdata  in  DATA_WIDTH  CPU write data.
- m0_rdata  out  DATA_WIDTH  read data to CPU.
- m0_ack  out  1  CPU transfer completes this cycle.
- cpu_stall  out  1  CPU must hold PC and state this cycle.
- m1_req  in  1  DMA request.
- m1_lock  in  1  DMA requests burst retention.
- m1_ctrl  in  3  DMA control, same encoding as m0_ctrl.
- m1_addr  in  ADDR_WIDTH  DMA address.
- m1_wdata  in  DATA_WIDTH  DMA write data.
- m1_rdata  out  DATA_WIDTH  read data to DMA.
- m1_ack  out  1  DMA transfer completes this cycle.
- mem_addr  out  ADDR_WIDTH  to memory AddressBus.
- mem_wdata  out  DATA_WIDTH  to memory DataMemoryInput.
- mem_ctrl  out  3  to memory control: bit1 MemReadEn, bit2 MemWriteEn.
- mem_rdata  in  DATA_WIDTH  from memory DataMemoryOutput.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit), burst_cnt (4 bits).
- Reset values: state=IDLE, last_owner=1 (so master 0 wins the first tie), burst_cnt=0.
- Reset values of outputs: all acks 0, mem_ctrl=0, mem_addr=0, mem_wdata=0, rdata outputs 0, cpu_stall=m0_req.
- Reset mid-operation aborts the current owner immediately. No write is issued while rst is low (mem_ctrl is forced to 0).
- Next-owner decision, evaluated every edge:
  - Only one requester: it owns the bus.
  - Both requesting: the master opposite last_owner owns the bus.
  - Neither requesting: IDLE.
- Lock exception: if state=OWN1, m1_req=1, m1_lock=1 and burst_cnt<MAX_BURST-1, stay in OWN1 regardless of m0_req. burst_cnt increments.
  - Leaving OWN1, or any cycle with m1_lock=0: burst_cnt is cleared.
- On entering OWNx, last_owner<=x.
- Ownership is held only while the owner's req is high. A req drop returns the FSM to arbitration at the next edge. There is no idle-cycle penalty when the other master is waiting.
- Datapath (combinational from state):
  - OWNx with mx_req=1: mem_addr, mem_wdata and mem_ctrl are taken from master x. mx_ack=1. mx_rdata=mem_rdata.
  - Otherwise: mem_ctrl=0, mem_addr and mem_wdata hold 0, acks are 0, rdata outputs are 0.
- Latency:
  - From IDLE, a request sees ack on the cycle after req rises (one-cycle grant latency).
  - Back-to-back requests from the current owner ack every cycle while uncontested.
- cpu_stall = m0_req & ~m0_ack.
- Simultaneous req rise from IDLE after reset: master 0 first, then alternation every cycle while both hold req and m1_lock=0.
- Masters must hold ctrl, addr and wdata stable while req=1 and ack=0. The arbiter does not latch them.
- m1_lock without m1_req is ignored.
- MAX_BURST=1 disables locking.

Optional Feature:
- ARB_STATS_EN: when defined, adds outputs grant0_cnt, grant1_cnt and contend_cnt (each DATA_WIDTH).
  - grant0_cnt / grant1_cnt count ack cycles per master.
  - contend_cnt counts cycles with m0_req & m1_req.
  - All counters reset to 0, saturate at all-ones, and feed a $display of totals in the sim top at finish.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset release, m0_req=1 read addr 0x10, m1_req=0 -> cycle 1: cpu_stall=1, m0_ack=0; cycle 2: m0_ack=1, mem_ctrl=3'b010, mem_addr=0x10, cpu_stall=0.
- Both req from IDLE, m1_lock=0, held 6 cycles -> acks alternate m0,m1,m0,m1,m0 after the first grant cycle; cpu_stall high exactly on m1 cycles.
- m1 owns, m1_lock=1, m0_req=1, MAX_BURST=4 -> m1_ack for 4 consecutive cycles, then m0_ack next cycle, burst_cnt=0.
- m1 write 0xDEADBEEF to 0x40, then m0 read 0x40 -> m0_rdata=0xDEADBEEF; mem_ctrl=3'b100 during the m1 ack cycle.
- rst pulled low mid-burst while in OWN1 with write pending -> mem_ctrl=0 immediately; after release, state IDLE and m0 wins the tie.
- ARB_STATS_EN, 10 cycles both requesting unlocked -> contend_cnt=10, grant0_cnt+grant1_cnt=9 (first cycle is grant latency).
